popcount_pattern_gen: RTL and testbench
=======================================

# popcount_pattern_gen

- Generates, for a requested ones-count `k`, every `W`-bit pattern whose popcount equals `k`.
- Patterns come out in ascending numeric order, one per cycle, over a valid/ready stream.
- It is the inverse of the `sum` popcount block: `sum` maps a pattern to its count; this block maps a count to all of its patterns.
- Used as a stimulus source and self-check partner for `sum`.

## Interface
Parameters:
- `W`, default 4: pattern width; must be ≥ 1.
- `CW`, default `$clog2(W+1)`: width of the count `k`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request carries a valid `req_k`.
- `req_ready` out 1: block is idle and can accept a request.
- `req_k` in CW: requested popcount.
- `out_valid` out 1: `out_pattern` is valid.
- `out_ready` in 1: downstream accepts the pattern.
- `out_pattern` out W: current pattern.
- `out_last` out 1: current pattern is the final one for this `k`.
- `out_index` out W: 0-based ordinal of the current pattern.
- `err` out 1: one-cycle pulse when a request has `req_k > W`.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - RUN: `out_valid`=1.
- IDLE, request handshake (`req_valid && req_ready`):
  - If `req_k ≤ W`: latch `k`, load `out_pattern = (1<<k)-1`, `out_index=0`, go to RUN.
  - If `req_k > W`: pulse `err` for one cycle, stay in IDLE, produce no output.
- RUN, output handshake (`out_valid && out_ready`):
  - If `out_last`=0: advance to the next pattern in the same cycle with the same popcount; `out_index` += 1.
  - If `out_last`=1: go to IDLE.
- `out_last` is asserted when `out_pattern == ((1<<k)-1) << (W-k)`.
  - `k`=0 yields a single pattern 0 with `out_last`=1.
  - `k`=W yields a single pattern of all ones with `out_last`=1.
- Next-pattern rule (standard next-combination):
  - `c = x & -x`, `r = x + c`, `next = (((r ^ x) >> 2) >> ctz(x)) | r`.
  - Computed modulo 2^(W+1) internally; only the low `W` bits are kept.
  - The rule is never evaluated on the last pattern.
- Number of patterns per request is C(W,k); `out_index` ends at C(W,k)-1.
- Backpressure: while `out_valid && !out_ready`, `out_pattern`, `out_last` and `out_index` hold stable.
- Requests are not accepted during RUN (`req_ready`=0); `req_valid` in RUN is ignored and not queued.
- Reset values: `req_ready`=1, `out_valid`=0, `out_pattern`=0, `out_last`=0, `out_index`=0, `err`=0, state IDLE.
- Reset asserted mid-stream aborts immediately.
  - Outputs go to reset values asynchronously.
  - No partial stream resumes after reset is released.

## Timing
- Request accepted at edge N → `out_valid`=1 with the first pattern after edge N.
- Throughput is one pattern per cycle while `out_ready`=1; no bubbles between patterns of one request.
- Final handshake at edge M → `out_valid`=0 and `req_ready`=1 after edge M.
  - A new request can be accepted at edge M+1.
  - There is exactly one IDLE cycle between streams.
- `err` is high for exactly the cycle after the rejecting handshake.
- All outputs are registered; there is no combinational path from `out_ready` or `req_valid` to any output.

## Structure
- Shared package `popcount_pkg` holds:
  - State enum `{IDLE, RUN}`.
  - Function `first_pattern(k)`.
  - Function `last_pattern(k)`.
- Sub-module `next_comb #(W)`: purely combinational next-combination, `x` in → `next` out, including a trailing-zero count.
- Top level holds the FSM, registers and handshake logic.

## Test plan
W=4 unless noted.
- `k`=2, `out_ready`=1 constantly:
  - Patterns 3,5,6,9,10,12 on 6 consecutive cycles.
  - `out_index` 0..5; `out_last` only on 12.
  - `req_ready` returns 1 one cycle later.
- `k`=0, then `k`=4:
  - Single pattern 0 with `out_last`=1, then single pattern 15 with `out_last`=1.
- `k`=1, `out_ready` toggling 1,0,0,1,0,1,1:
  - Emits 1,2,4,8.
  - Outputs hold stable during every stall; no pattern skipped or duplicated.
- `k`=5:
  - `err`=1 for one cycle; `out_valid` stays 0; `req_ready` stays 1.
  - A following `k`=3 request yields 7,11,13,14.
- `req_valid` pulsed during RUN is ignored. Reset dropped after the second pattern:
  - `out_valid`=0 and `out_index`=0 asynchronously.
  - After release, `req_ready`=1.
- W=6 self-check: every `k` 0..6, each `out_pattern` fed into `sum`-style popcount.
  - Popcount equals `k`.
  - Stream length equals C(6,k): 1,6,15,20,15,6,1.
  - Patterns strictly ascending.

Source files
------------

// File: rtl/popcount_pattern_gen_pkg.sv
// rtl/popcount_pattern_gen_pkg.sv - shared types and pattern helpers for popcount_pattern_gen
package popcount_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widest pattern the helpers can describe; callers narrow the result to their own width.
    localparam int MAX_W = 32;

    // Smallest pattern with k ones: the k low bits set.
    function automatic logic [MAX_W-1:0] first_pattern(input int k);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < k) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Largest w-bit pattern with k ones: the k high bits of the w-bit field set.
    function automatic logic [MAX_W-1:0] last_pattern(input int k, input int w);
        if (k > w) return '0;
        return first_pattern(k) << (w - k);
    endfunction

endpackage

// File: rtl/popcount_pattern_gen_if.sv
// rtl/popcount_pattern_gen_if.sv - request and pattern stream bundle for popcount_pattern_gen
interface popcount_pattern_gen_if #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
);
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_k;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_pattern;
    logic          out_last;
    logic [W-1:0]  out_index;
    logic          err;

    modport master (
        output req_valid, req_k, out_ready,
        input  req_ready, out_valid, out_pattern, out_last, out_index, err
    );

    modport slave (
        input  req_valid, req_k, out_ready,
        output req_ready, out_valid, out_pattern, out_last, out_index, err
    );
endinterface

// File: rtl/popcount_pattern_gen_next_comb.sv
// rtl/popcount_pattern_gen_next_comb.sv - combinational next pattern with equal popcount
module next_comb #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_next
);
    localparam int TW = (W > 1) ? $clog2(W) : 1;

    // One extra bit so the carry out of the lowest run of ones is not lost.
    logic [W:0]    w_x;
    logic [W:0]    w_c;
    logic [W:0]    w_r;
    logic [TW-1:0] w_ctz;

    assign w_x = {1'b0, i_x};
    assign w_c = w_x & (-w_x);
    assign w_r = w_x + w_c;

    // Trailing-zero count: position of the lowest set bit of the input.
    always_comb begin
        w_ctz = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_x[i]) w_ctz = TW'(i);
        end
    end

    assign o_next = W'((((w_r ^ w_x) >> 2) >> w_ctz) | w_r);
endmodule

// File: rtl/popcount_pattern_gen.sv
// rtl/popcount_pattern_gen.sv - streams every W-bit pattern with a requested popcount
module popcount_pattern_gen #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input logic                 clk,
    input logic                 rst,
    popcount_pattern_gen_if.slave s_if
);
    import popcount_pkg::*;

    state_t        r_state,   w_state_nxt;
    logic [CW-1:0] r_k,       w_k_nxt;
    logic [W-1:0]  r_pattern, w_pattern_nxt;
    logic [W-1:0]  r_index,   w_index_nxt;
    logic          r_last,    w_last_nxt;
    logic          r_err,     w_err_nxt;

    logic [W-1:0]  w_next;
    logic [W-1:0]  w_first_req;
    logic [W-1:0]  w_last_req;
    logic [W-1:0]  w_last_cur;

    next_comb #(.W(W)) u_next_comb (
        .i_x    (r_pattern),
        .o_next (w_next)
    );

    assign w_first_req = W'(first_pattern(int'(s_if.req_k)));
    assign w_last_req  = W'(last_pattern(int'(s_if.req_k), W));
    assign w_last_cur  = W'(last_pattern(int'(r_k), W));

    // Every output comes straight from a register; none depends on this cycle's inputs.
    assign s_if.req_ready   = (r_state == IDLE);
    assign s_if.out_valid   = (r_state == RUN);
    assign s_if.out_pattern = r_pattern;
    assign s_if.out_last    = r_last;
    assign s_if.out_index   = r_index;
    assign s_if.err         = r_err;

    // Next-state and next-register values: accept or reject a request, then walk the patterns.
    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_pattern_nxt = r_pattern;
        w_index_nxt   = r_index;
        w_last_nxt    = r_last;
        w_err_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (s_if.req_valid) begin
                    if (int'(s_if.req_k) > W) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_k_nxt       = s_if.req_k;
                        w_pattern_nxt = w_first_req;
                        w_index_nxt   = '0;
                        w_last_nxt    = (w_first_req == w_last_req);
                        w_state_nxt   = RUN;
                    end
                end
            end
            RUN: begin
                if (s_if.out_ready) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_pattern_nxt = w_next;
                        w_index_nxt   = r_index + W'(1);
                        w_last_nxt    = (w_next == w_last_cur);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any stream immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_pattern <= '0;
            r_index   <= '0;
            r_last    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_pattern <= w_pattern_nxt;
            r_index   <= w_index_nxt;
            r_last    <= w_last_nxt;
            r_err     <= w_err_nxt;
        end
    end
endmodule

// File: tb/tb_popcount_pattern_gen.sv
// tb/tb_popcount_pattern_gen.sv - scoreboard bench for popcount_pattern_gen
module tb_popcount_pattern_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    popcount_pattern_gen_if #(.W(4)) if4 ();
    popcount_pattern_gen_if #(.W(6)) if6 ();

    popcount_pattern_gen #(.W(4)) dut4 (.clk(clk), .rst(rst), .s_if(if4.slave));
    popcount_pattern_gen #(.W(6)) dut6 (.clk(clk), .rst(rst), .s_if(if6.slave));

    typedef struct {
        logic [3:0] pat;
        logic [3:0] idx;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference: scan all 4-bit values in ascending order, keep those with k ones.
    task automatic push_expected(input int k);
        int   total;
        int   n;
        exp_t e;
        total = 0;
        for (int v = 0; v < 16; v++) if ($countones(v[3:0]) == k) total++;
        n = 0;
        for (int v = 0; v < 16; v++) begin
            if ($countones(v[3:0]) == k) begin
                e.pat  = v[3:0];
                e.idx  = n[3:0];
                e.last = (n == total - 1);
                sb.push_back(e);
                n++;
            end
        end
    endtask

    task automatic send4(input int k);
        if4.req_valid = 1'b1;
        if4.req_k     = k[2:0];
        if (k <= 4) push_expected(k);
        @(posedge clk);
        #1;
        if4.req_valid = 1'b0;
    endtask

    task automatic drain4(input logic [15:0] rpat, input int rlen, input string name, output int cyc);
        logic       held;
        logic [3:0] hp, hi;
        logic       hl;
        exp_t       e;
        cyc  = 0;
        held = 1'b0;
        while (sb.size() > 0 && cyc < 100) begin
            @(negedge clk);
            if (held) begin
                checks++;
                if ({if4.out_pattern, if4.out_index, if4.out_last} !== {hp, hi, hl}) begin
                    failures++;
                    $display("FAIL %s stall_hold got=%0d/%0d/%0d exp=%0d/%0d/%0d", name,
                             if4.out_pattern, if4.out_index, if4.out_last, hp, hi, hl);
                end
            end
            if4.out_ready = rpat[cyc % rlen];
            held = 1'b0;
            checks++;
            if (if4.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s out_valid got=%b exp=1 cycle=%0d", name, if4.out_valid, cyc);
            end else if (if4.out_ready) begin
                e = sb.pop_front();
                if ({if4.out_pattern, if4.out_index, if4.out_last} !== {e.pat, e.idx, e.last}) begin
                    failures++;
                    $display("FAIL %s pattern/index/last got=%0d/%0d/%0d exp=%0d/%0d/%0d", name,
                             if4.out_pattern, if4.out_index, if4.out_last, e.pat, e.idx, e.last);
                end
            end else begin
                held = 1'b1;
                hp = if4.out_pattern;
                hi = if4.out_index;
                hl = if4.out_last;
            end
            cyc++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout remaining=%0d exp=0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
        checks++;
        if (if4.req_ready !== 1'b1 || if4.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after got req_ready=%b out_valid=%b exp 1/0", name,
                     if4.req_ready, if4.out_valid);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({if4.req_ready, if4.out_valid, if4.out_pattern, if4.out_last, if4.out_index, if4.err}
            !== {1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_w4 got rr=%b ov=%b pat=%0d last=%b idx=%0d err=%b exp 1/0/0/0/0/0",
                     if4.req_ready, if4.out_valid, if4.out_pattern, if4.out_last, if4.out_index, if4.err);
        end
        checks++;
        if ({if6.req_ready, if6.out_valid, if6.out_pattern, if6.out_index, if6.err}
            !== {1'b1, 1'b0, 6'd0, 6'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_w6 got rr=%b ov=%b pat=%0d idx=%0d err=%b exp 1/0/0/0/0",
                     if6.req_ready, if6.out_valid, if6.out_pattern, if6.out_index, if6.err);
        end
    endtask

    task automatic test_k2;
        int cyc;
        @(negedge clk);
        if4.out_ready = 1'b1;
        send4(2);
        drain4(16'h0001, 1, "k2", cyc);
        checks++;
        if (cyc !== 6) begin
            failures++;
            $display("FAIL k2_cycles got=%0d exp=6", cyc);
        end
    endtask

    task automatic test_k0_k4;
        int cyc;
        send4(0);
        drain4(16'h0001, 1, "k0", cyc);
        send4(4);
        drain4(16'h0001, 1, "k4", cyc);
    endtask

    task automatic test_backpressure;
        int cyc;
        send4(1);
        drain4(16'b1101001, 7, "k1_stall", cyc);
        checks++;
        if (cyc !== 7) begin
            failures++;
            $display("FAIL k1_stall_cycles got=%0d exp=7", cyc);
        end
    endtask

    task automatic test_err;
        int cyc;
        send4(5);
        @(negedge clk);
        checks++;
        if ({if4.err, if4.out_valid, if4.req_ready} !== 3'b101) begin
            failures++;
            $display("FAIL err_pulse got err/ov/rr=%b%b%b exp=101", if4.err, if4.out_valid, if4.req_ready);
        end
        @(negedge clk);
        checks++;
        if ({if4.err, if4.out_valid} !== 2'b00) begin
            failures++;
            $display("FAIL err_clear got err/ov=%b%b exp=00", if4.err, if4.out_valid);
        end
        send4(3);
        drain4(16'h0001, 1, "k3_after_err", cyc);
    endtask

    task automatic test_ignore_and_reset;
        exp_t e;
        if4.out_ready = 1'b1;
        send4(2);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            if4.req_valid = (n == 0);
            if4.req_k     = 3'd1;
            e = sb.pop_front();
            checks++;
            if ({if4.out_valid, if4.out_pattern, if4.out_index} !== {1'b1, e.pat, e.idx}) begin
                failures++;
                $display("FAIL run_ignore got ov=%b pat=%0d idx=%0d exp 1/%0d/%0d",
                         if4.out_valid, if4.out_pattern, if4.out_index, e.pat, e.idx);
            end
        end
        if4.req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({if4.out_valid, if4.out_index, if4.out_pattern, if4.req_ready} !== {1'b0, 4'd0, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL async_reset got ov=%b idx=%0d pat=%0d rr=%b exp 0/0/0/1",
                     if4.out_valid, if4.out_index, if4.out_pattern, if4.req_ready);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if ({if4.out_valid, if4.req_ready} !== 2'b01) begin
                failures++;
                $display("FAIL no_resume got ov=%b rr=%b exp 0/1", if4.out_valid, if4.req_ready);
            end
        end
    endtask

    task automatic test_w6;
        int binom[7] = '{1, 6, 15, 20, 15, 6, 1};
        int n;
        int prev;
        int cyc;
        logic done;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if6.req_valid = 1'b1;
            if6.req_k     = k[2:0];
            @(posedge clk);
            #1;
            if6.req_valid = 1'b0;
            if6.out_ready = 1'b1;
            n    = 0;
            prev = -1;
            cyc  = 0;
            done = 1'b0;
            while (!done && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (if6.out_valid) begin
                    checks++;
                    if ($countones(if6.out_pattern) != k || int'(if6.out_pattern) <= prev
                        || int'(if6.out_index) != n) begin
                        failures++;
                        $display("FAIL w6_k%0d pattern=%0d popcount=%0d idx=%0d prev=%0d exp popcount=%0d idx=%0d ascending",
                                 k, if6.out_pattern, $countones(if6.out_pattern), if6.out_index, prev, k, n);
                    end
                    prev = int'(if6.out_pattern);
                    n++;
                    done = if6.out_last;
                end
            end
            checks++;
            if (n != binom[k] || !done) begin
                failures++;
                $display("FAIL w6_k%0d_length got=%0d exp=%0d", k, n, binom[k]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst           = 1'b1;
        if4.req_valid = 1'b0;
        if4.req_k     = '0;
        if4.out_ready = 1'b0;
        if6.req_valid = 1'b0;
        if6.req_k     = '0;
        if6.out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #10;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_k2();
        test_k0_k4();
        test_backpressure();
        test_err();
        test_ignore_and_reset();
        test_w6();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
